// File: rtl/mips_idex_stage.sv
// ID/EX pipeline register, operand select and RAW hazard detection for the lab4 MIPS core.
// Build option: define MIPS_FORWARDING_EN to enable EX/MEM + MEM/WB forwarding (load-use stalls only).
module mips_idex_stage #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic          id_valid,
   input  logic [RW-1:0] id_rs_num,
   input  logic [RW-1:0] id_rt_num,
   input  logic [DW-1:0] id_rs_data,
   input  logic [DW-1:0] id_rt_data,
   input  logic [DW-1:0] id_imm,
   input  logic          id_use_imm,
   input  logic          id_uses_rt,
   input  logic [RW-1:0] id_wr_num,
   input  logic          id_reg_we,
   input  logic          id_mem_read,
   input  logic          id_mem_write,
   input  logic [3:0]    id_alu_sel,
   input  logic [2:0]    id_brcond,
   input  logic          hold,
   input  logic          flush,
   input  logic          exmem_we,
   input  logic [RW-1:0] exmem_wr_num,
   input  logic [DW-1:0] exmem_result,
   input  logic          memwb_we,
   input  logic [RW-1:0] memwb_wr_num,
   input  logic [DW-1:0] memwb_result,
   output logic          id_stall,
   output logic          ex_valid,
   output logic [DW-1:0] alu__op1,
   output logic [DW-1:0] alu__op2,
   output logic [3:0]    alu__sel,
   output logic [2:0]    brcond,
   output logic [DW-1:0] ex_store_data,
   output logic [RW-1:0] ex_wr_num,
   output logic          ex_reg_we,
   output logic          ex_mem_read,
   output logic          ex_mem_write
);

   logic          valid_q, valid_d;
   logic [RW-1:0] rs_num_q, rs_num_d, rt_num_q, rt_num_d, wr_num_q, wr_num_d;
   logic [DW-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
   logic          use_imm_q, use_imm_d, reg_we_q, reg_we_d;
   logic          mem_read_q, mem_read_d, mem_write_q, mem_write_d;
   logic [3:0]    alu_sel_q, alu_sel_d;
   logic [2:0]    brcond_q, brcond_d;
   logic          stall, ex_hit, mem_hit;
   logic [DW-1:0] rs_fwd, rt_fwd;

   function automatic logic reads_reg(input logic [RW-1:0] num, input logic [RW-1:0] rs,
                                      input logic [RW-1:0] rt, input logic uses_rt);
      return (num != '0) && ((num == rs) || (uses_rt && (num == rt)));
   endfunction

`ifdef MIPS_FORWARDING_EN
   function automatic logic [DW-1:0] fwd(input logic [RW-1:0] num, input logic [DW-1:0] cap);
      if (num == '0)                               return '0;
      else if (exmem_we && (exmem_wr_num == num))  return exmem_result;
      else if (memwb_we && (memwb_wr_num == num))  return memwb_result;
      else                                         return cap;
   endfunction

   // Only a load still in EX cannot be forwarded in time.
   assign ex_hit  = valid_q && mem_read_q && reads_reg(wr_num_q, id_rs_num, id_rt_num, id_uses_rt);
   assign mem_hit = 1'b0;
   assign rs_fwd  = fwd(rs_num_q, rs_data_q);
   assign rt_fwd  = fwd(rt_num_q, rt_data_q);
`else
   logic unused_nofwd;

   // Producers in EX or EX/MEM stall ID until they reach MEM/WB, where capture bypass picks them up.
   assign ex_hit       = valid_q && reg_we_q && reads_reg(wr_num_q, id_rs_num, id_rt_num, id_uses_rt);
   assign mem_hit      = exmem_we && reads_reg(exmem_wr_num, id_rs_num, id_rt_num, id_uses_rt);
   assign rs_fwd       = rs_data_q;
   assign rt_fwd       = rt_data_q;
   assign unused_nofwd = ^{exmem_result, rs_num_q, rt_num_q};
`endif

   // Suppressed under flush: the stalled ID instruction is being killed anyway.
   assign stall = rst_b && !flush && id_valid && (ex_hit || mem_hit);

   always_comb begin
      valid_d     = valid_q;
      rs_num_d    = rs_num_q;
      rt_num_d    = rt_num_q;
      rs_data_d   = rs_data_q;
      rt_data_d   = rt_data_q;
      imm_d       = imm_q;
      use_imm_d   = use_imm_q;
      wr_num_d    = wr_num_q;
      reg_we_d    = reg_we_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      alu_sel_d   = alu_sel_q;
      brcond_d    = brcond_q;
      if (!hold) begin
         if (flush || stall) begin
            valid_d     = 1'b0;
            rs_num_d    = '0;
            rt_num_d    = '0;
            rs_data_d   = '0;
            rt_data_d   = '0;
            imm_d       = '0;
            use_imm_d   = 1'b0;
            wr_num_d    = '0;
            reg_we_d    = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            alu_sel_d   = '0;
            brcond_d    = '0;
         end else begin
            // The regfile does not write through, so pick up a same-cycle writeback here.
            valid_d     = id_valid;
            rs_num_d    = id_rs_num;
            rt_num_d    = id_rt_num;
            rs_data_d   = (memwb_we && (memwb_wr_num != '0) && (memwb_wr_num == id_rs_num))
                          ? memwb_result : id_rs_data;
            rt_data_d   = (memwb_we && (memwb_wr_num != '0) && (memwb_wr_num == id_rt_num))
                          ? memwb_result : id_rt_data;
            imm_d       = id_imm;
            use_imm_d   = id_use_imm;
            wr_num_d    = id_wr_num;
            reg_we_d    = id_valid && id_reg_we;
            mem_read_d  = id_valid && id_mem_read;
            mem_write_d = id_valid && id_mem_write;
            alu_sel_d   = id_alu_sel;
            brcond_d    = id_brcond;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         valid_q     <= 1'b0;
         rs_num_q    <= '0;
         rt_num_q    <= '0;
         rs_data_q   <= '0;
         rt_data_q   <= '0;
         imm_q       <= '0;
         use_imm_q   <= 1'b0;
         wr_num_q    <= '0;
         reg_we_q    <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         alu_sel_q   <= '0;
         brcond_q    <= '0;
      end else begin
         valid_q     <= valid_d;
         rs_num_q    <= rs_num_d;
         rt_num_q    <= rt_num_d;
         rs_data_q   <= rs_data_d;
         rt_data_q   <= rt_data_d;
         imm_q       <= imm_d;
         use_imm_q   <= use_imm_d;
         wr_num_q    <= wr_num_d;
         reg_we_q    <= reg_we_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         alu_sel_q   <= alu_sel_d;
         brcond_q    <= brcond_d;
      end
   end

   assign id_stall      = stall;
   assign ex_valid      = valid_q;
   assign alu__op1      = rs_fwd;
   assign alu__op2      = use_imm_q ? imm_q : rt_fwd;
   assign alu__sel      = alu_sel_q;
   assign brcond        = brcond_q;
   assign ex_store_data = rt_fwd;
   assign ex_wr_num     = wr_num_q;
   assign ex_reg_we     = reg_we_q;
   assign ex_mem_read   = mem_read_q;
   assign ex_mem_write  = mem_write_q;

endmodule

// File: tb/tb_mips_idex_stage.sv
// Self-checking bench for mips_idex_stage: directed table, hazard/flush/hold/reset sequences,
// then random stimulus against a pipeline-level reference model. Honours MIPS_FORWARDING_EN.
module tb_mips_idex_stage;
   localparam int DW = 32;
   localparam int RW = 5;
`ifdef MIPS_FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_b;
   logic          id_valid, id_use_imm, id_uses_rt, id_reg_we, id_mem_read, id_mem_write;
   logic [RW-1:0] id_rs_num, id_rt_num, id_wr_num;
   logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
   logic [3:0]    id_alu_sel;
   logic [2:0]    id_brcond;
   logic          hold, flush;
   logic          exmem_we, memwb_we;
   logic [RW-1:0] exmem_wr_num, memwb_wr_num;
   logic [DW-1:0] exmem_result, memwb_result;
   logic          id_stall, ex_valid, ex_reg_we, ex_mem_read, ex_mem_write;
   logic [DW-1:0] alu__op1, alu__op2, ex_store_data;
   logic [3:0]    alu__sel;
   logic [2:0]    brcond;
   logic [RW-1:0] ex_wr_num;

   int n_vec = 0;
   int n_err = 0;

   mips_idex_stage #(.DW(DW), .RW(RW)) dut (
      .clk(clk), .rst_b(rst_b),
      .id_valid(id_valid), .id_rs_num(id_rs_num), .id_rt_num(id_rt_num),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_use_imm(id_use_imm), .id_uses_rt(id_uses_rt), .id_wr_num(id_wr_num),
      .id_reg_we(id_reg_we), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_alu_sel(id_alu_sel), .id_brcond(id_brcond), .hold(hold), .flush(flush),
      .exmem_we(exmem_we), .exmem_wr_num(exmem_wr_num), .exmem_result(exmem_result),
      .memwb_we(memwb_we), .memwb_wr_num(memwb_wr_num), .memwb_result(memwb_result),
      .id_stall(id_stall), .ex_valid(ex_valid), .alu__op1(alu__op1), .alu__op2(alu__op2),
      .alu__sel(alu__sel), .brcond(brcond), .ex_store_data(ex_store_data),
      .ex_wr_num(ex_wr_num), .ex_reg_we(ex_reg_we), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model: the instruction sitting in EX ----------------
   typedef struct packed {
      logic        valid;
      logic [4:0]  rs, rt, wr;
      logic [31:0] rs_d, rt_d, imm;
      logic        use_imm, we, mr, mw;
      logic [3:0]  sel;
      logic [2:0]  br;
   } ex_t;

   ex_t m = '0;

   // Value the regfile delivers in ID, including a writeback landing this same cycle.
   function automatic logic [31:0] rf_read(input logic [4:0] num, input logic [31:0] rf);
      if (memwb_we && num != 5'd0 && memwb_wr_num == num) return memwb_result;
      return rf;
   endfunction

   // Operand as EX sees it: newest in-flight value wins, $0 is hard zero.
   function automatic logic [31:0] operand(input logic [4:0] num, input logic [31:0] cap);
      if (!FWD) return cap;
      if (num == 5'd0) return 32'd0;
      if (exmem_we && exmem_wr_num == num) return exmem_result;
      if (memwb_we && memwb_wr_num == num) return memwb_result;
      return cap;
   endfunction

   // Stall when ID reads a register that a not-yet-forwardable producer will write.
   function automatic logic model_stall();
      logic [4:0] producers[$];
      logic       hit;
      hit = 1'b0;
      if (FWD) begin
         if (m.valid && m.mr) producers.push_back(m.wr);
      end else begin
         if (m.valid && m.we) producers.push_back(m.wr);
         if (exmem_we) producers.push_back(exmem_wr_num);
      end
      foreach (producers[i])
         if (producers[i] != 5'd0 &&
             (producers[i] == id_rs_num || (id_uses_rt && producers[i] == id_rt_num)))
            hit = 1'b1;
      return rst_b && !flush && id_valid && hit;
   endfunction

   task automatic model_update();
      ex_t nxt;
      if (!rst_b) begin
         m = '0;
      end else if (!hold) begin
         if (flush || model_stall()) begin
            m = '0;
         end else begin
            nxt.valid   = id_valid;
            nxt.rs      = id_rs_num;
            nxt.rt      = id_rt_num;
            nxt.wr      = id_wr_num;
            nxt.rs_d    = rf_read(id_rs_num, id_rs_data);
            nxt.rt_d    = rf_read(id_rt_num, id_rt_data);
            nxt.imm     = id_imm;
            nxt.use_imm = id_use_imm;
            nxt.we      = id_valid & id_reg_we;
            nxt.mr      = id_valid & id_mem_read;
            nxt.mw      = id_valid & id_mem_write;
            nxt.sel     = id_alu_sel;
            nxt.br      = id_brcond;
            m = nxt;
         end
      end
   endtask

   // ---------------- scoreboard helpers ----------------
   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model(input string tag);
      logic [31:0] rt_v;
      rt_v = operand(m.rt, m.rt_d);
      cmp({tag, ".stall"}, 32'(id_stall), 32'(model_stall()));
      cmp({tag, ".valid"}, 32'(ex_valid), 32'(m.valid));
      cmp({tag, ".op1"}, alu__op1, operand(m.rs, m.rs_d));
      cmp({tag, ".op2"}, alu__op2, m.use_imm ? m.imm : rt_v);
      cmp({tag, ".store"}, ex_store_data, rt_v);
      cmp({tag, ".sel"}, 32'(alu__sel), 32'(m.sel));
      cmp({tag, ".br"}, 32'(brcond), 32'(m.br));
      cmp({tag, ".wr"}, 32'(ex_wr_num), 32'(m.wr));
      cmp({tag, ".ctl"}, {29'd0, ex_reg_we, ex_mem_read, ex_mem_write}, {29'd0, m.we, m.mr, m.mw});
   endtask

   task automatic check_all_zero(input string tag);
      cmp({tag, ".stall"}, 32'(id_stall), 32'd0);
      cmp({tag, ".valid"}, 32'(ex_valid), 32'd0);
      cmp({tag, ".op1"}, alu__op1, 32'd0);
      cmp({tag, ".op2"}, alu__op2, 32'd0);
      cmp({tag, ".store"}, ex_store_data, 32'd0);
      cmp({tag, ".fields"}, {20'd0, alu__sel, brcond, ex_wr_num},  32'd0);
      cmp({tag, ".ctl"}, {29'd0, ex_reg_we, ex_mem_read, ex_mem_write}, 32'd0);
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic clear_inputs();
      id_valid = 0; id_rs_num = 0; id_rt_num = 0; id_rs_data = 0; id_rt_data = 0;
      id_imm = 0; id_use_imm = 0; id_uses_rt = 0; id_wr_num = 0; id_reg_we = 0;
      id_mem_read = 0; id_mem_write = 0; id_alu_sel = 0; id_brcond = 0;
      hold = 0; flush = 0;
      exmem_we = 0; exmem_wr_num = 0; exmem_result = 0;
      memwb_we = 0; memwb_wr_num = 0; memwb_result = 0;
   endtask

   task automatic rand_inputs();
      id_valid     = ($urandom_range(0, 9) < 8);
      id_rs_num    = 5'($urandom_range(0, 3));
      id_rt_num    = 5'($urandom_range(0, 3));
      id_rs_data   = $urandom;
      id_rt_data   = $urandom;
      id_imm       = $urandom;
      id_use_imm   = 1'($urandom_range(0, 1));
      id_uses_rt   = 1'($urandom_range(0, 1));
      id_wr_num    = 5'($urandom_range(0, 3));
      id_reg_we    = 1'($urandom_range(0, 1));
      id_mem_read  = ($urandom_range(0, 9) < 3);
      id_mem_write = 1'($urandom_range(0, 1));
      id_alu_sel   = 4'($urandom);
      id_brcond    = 3'($urandom);
      hold         = ($urandom_range(0, 9) == 0);
      flush        = ($urandom_range(0, 9) == 0);
      exmem_we     = 1'($urandom_range(0, 1));
      exmem_wr_num = 5'($urandom_range(0, 3));
      exmem_result = $urandom;
      memwb_we     = 1'($urandom_range(0, 1));
      memwb_wr_num = 5'($urandom_range(0, 3));
      memwb_result = $urandom;
   endtask

   // Producer writing $3, then a consumer reading $3 as rt; counts stall cycles and checks
   // the operand the consumer finally sees is the produced value (32'hABCD).
   task automatic seq_raw(input bit load, input int exp_stalls);
      int stalls;
      bit captured, checked, prev_stall;
      clear_inputs();
      id_valid = 1; id_wr_num = 3; id_reg_we = 1; id_mem_read = load; id_rs_num = 1;
      @(negedge clk);
      tick();
      stalls = 0; captured = 0; checked = 0; prev_stall = 0;
      for (int c = 1; c <= 5; c++) begin
         if (!checked) begin
            exmem_we = (c == 2); exmem_wr_num = 3; exmem_result = load ? 32'h100 : 32'hABCD;
            memwb_we = (c == 3); memwb_wr_num = 3; memwb_result = 32'hABCD;
            id_valid = !captured; id_rs_num = 1; id_rs_data = 32'h11; id_rt_num = 3;
            id_rt_data = 32'hDEAD; id_uses_rt = 1; id_use_imm = 0; id_wr_num = 6;
            id_reg_we = 1; id_mem_read = 0;
            @(negedge clk);
            if (prev_stall) cmp("raw_bubble", 32'(ex_valid), 32'd0);
            prev_stall = 0;
            if (captured) begin
               cmp("raw_op2", alu__op2, 32'hABCD);
               cmp("raw_store", ex_store_data, 32'hABCD);
               cmp("raw_valid", 32'(ex_valid), 32'd1);
               checked = 1;
            end else if (id_stall) begin
               stalls++;
               prev_stall = 1;
            end else begin
               captured = 1;
            end
            tick();
         end
      end
      cmp(load ? "raw_load_stalls" : "raw_alu_stalls", 32'(stalls), 32'(exp_stalls));
      cmp("raw_done", 32'(checked), 32'd1);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct packed {
      logic [4:0]  rs, rt;
      logic [31:0] rs_d, rt_d, imm;
      logic        use_imm;
      logic        xm_we;
      logic [4:0]  xm_num;
      logic [31:0] xm_res;
      logic        wb_we;
      logic [4:0]  wb_num;
      logic [31:0] wb_res;
      logic [31:0] op1_f, op2_f, op1_n, op2_n;
   } vec_t;

   vec_t tbl[$];

   initial begin
      tbl.push_back('{5'd3, 5'd2, 32'h5, 32'h7, 32'h0, 1'b0, 1'b1, 5'd3, 32'h10,
                      1'b0, 5'd0, 32'h0, 32'h10, 32'h7, 32'h5, 32'h7});
      tbl.push_back('{5'd3, 5'd2, 32'h5, 32'h7, 32'h0, 1'b0, 1'b1, 5'd3, 32'h10,
                      1'b1, 5'd3, 32'h20, 32'h10, 32'h7, 32'h5, 32'h7});
      tbl.push_back('{5'd3, 5'd2, 32'h5, 32'h7, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0,
                      1'b1, 5'd2, 32'h33, 32'h5, 32'h33, 32'h5, 32'h7});
      tbl.push_back('{5'd0, 5'd2, 32'h0, 32'h7, 32'h7, 1'b1, 1'b1, 5'd0, 32'hFFFF,
                      1'b1, 5'd0, 32'hEEEE, 32'h0, 32'h7, 32'h0, 32'h7});
      tbl.push_back('{5'd3, 5'd2, 32'h5, 32'h7, 32'h0, 1'b0, 1'b0, 5'd3, 32'h10,
                      1'b0, 5'd0, 32'h0, 32'h5, 32'h7, 32'h5, 32'h7});
      tbl.push_back('{5'd1, 5'd1, 32'h55, 32'h55, 32'h0, 1'b0, 1'b1, 5'd2, 32'h99,
                      1'b1, 5'd1, 32'h77, 32'h77, 32'h77, 32'h55, 32'h55});
      tbl.push_back('{5'd2, 5'd3, 32'h5, 32'h7, 32'h1234, 1'b1, 1'b1, 5'd3, 32'h42,
                      1'b1, 5'd2, 32'h43, 32'h43, 32'h1234, 32'h5, 32'h1234});

      // ---- reset state (async, with ID and EX/MEM presenting a would-be hazard) ----
      clear_inputs();
      rst_b = 0;
      id_valid = 1; id_rs_num = 3; exmem_we = 1; exmem_wr_num = 3; exmem_result = 32'hFFFF;
      #3;
      check_all_zero("reset");
      @(negedge clk);
      rst_b = 1;
      clear_inputs();
      tick();

      // ---- table: capture one instruction, then present EX/MEM + MEM/WB sources ----
      foreach (tbl[i]) begin
         clear_inputs();
         id_valid = 1; id_rs_num = tbl[i].rs; id_rt_num = tbl[i].rt;
         id_rs_data = tbl[i].rs_d; id_rt_data = tbl[i].rt_d; id_imm = tbl[i].imm;
         id_use_imm = tbl[i].use_imm; id_alu_sel = 4'(i + 1); id_brcond = 3'(i);
         @(negedge clk);
         tick();
         exmem_we = tbl[i].xm_we; exmem_wr_num = tbl[i].xm_num; exmem_result = tbl[i].xm_res;
         memwb_we = tbl[i].wb_we; memwb_wr_num = tbl[i].wb_num; memwb_result = tbl[i].wb_res;
         @(negedge clk);
         cmp($sformatf("tbl%0d.op1", i), alu__op1, FWD ? tbl[i].op1_f : tbl[i].op1_n);
         cmp($sformatf("tbl%0d.op2", i), alu__op2, FWD ? tbl[i].op2_f : tbl[i].op2_n);
         cmp($sformatf("tbl%0d.sel", i), {alu__sel, 1'b0, brcond}, {4'(i + 1), 1'b0, 3'(i)});
         cmp($sformatf("tbl%0d.valid", i), 32'(ex_valid), 32'd1);
      end

      // ---- RAW sequences: load-use and ALU producer ----
      seq_raw(1'b1, FWD ? 1 : 2);
      seq_raw(1'b0, FWD ? 0 : 2);

      // ---- flush overrides a load-use stall ----
      clear_inputs();
      id_valid = 1; id_wr_num = 5; id_reg_we = 1; id_mem_read = 1; id_rs_num = 1;
      @(negedge clk);
      tick();
      id_valid = 1; id_rs_num = 1; id_rt_num = 5; id_uses_rt = 1; id_reg_we = 0; id_mem_read = 0;
      @(negedge clk);
      cmp("lu_stall", 32'(id_stall), 32'd1);
      flush = 1;
      #1;
      cmp("flush_stall", 32'(id_stall), 32'd0);
      tick();
      flush = 0; id_valid = 0;
      @(negedge clk);
      cmp("flush_bubble", {27'd0, ex_valid, ex_mem_read, ex_wr_num[2:0]}, 32'd0);
      tick();

      // ---- hold retains all fields, even against flush ----
      clear_inputs();
      id_valid = 1; id_rs_num = 1; id_rs_data = 32'h1111; id_wr_num = 7; id_reg_we = 1;
      id_alu_sel = 4'hA;
      @(negedge clk);
      tick();
      for (int k = 0; k < 4; k++) begin
         id_valid = 1; id_rs_num = 5'(k + 2); id_rs_data = $urandom; id_wr_num = 5'(k + 8);
         id_alu_sel = 4'(k); hold = 1; flush = (k >= 2);
         @(negedge clk);
         cmp("hold_wr", 32'(ex_wr_num), 32'd7);
         cmp("hold_sel", 32'(alu__sel), 32'hA);
         cmp("hold_ctl", {30'd0, ex_valid, ex_reg_we}, 32'h3);
         cmp("hold_op1", alu__op1, 32'h1111);
         tick();
      end

      // ---- reset mid-run ----
      clear_inputs();
      id_valid = 1; id_rs_num = 2; id_rs_data = 32'h5A5A; id_wr_num = 4; id_reg_we = 1;
      id_mem_read = 1; id_alu_sel = 4'h3;
      @(negedge clk);
      tick();
      cmp("pre_rst_valid", 32'(ex_valid), 32'd1);
      id_rs_num = 4; exmem_we = 1; exmem_wr_num = 2; exmem_result = 32'hFFFF;
      #2;
      rst_b = 0;
      m = '0;
      #1;
      check_all_zero("mid_rst");
      @(negedge clk);
      rst_b = 1;
      clear_inputs();
      tick();

      // ---- randomized run against the model ----
      for (int n = 0; n < 400; n++) begin
         rand_inputs();
         @(negedge clk);
         check_model("rand");
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
